// File: rtl/fetch_stage_if.sv
// fetch_stage_if: decode-decision inputs, instruction-memory port and IF/ID outputs of the fetch stage
interface fetch_stage_if;
  logic        stall;
  logic [2:0]  next_pc_op;
  logic        cmp_eq;
  logic [15:0] imm16;
  logic [25:0] j_address;
  logic [31:0] rs_data;
  logic [31:0] im_addr;
  logic [31:0] im_rdata;
  logic [31:0] pc_F;
  logic [31:0] instr_D;
  logic [31:0] pc_D;
  logic        valid_D;
  logic        pc_err;
  modport master (
    input  stall, next_pc_op, cmp_eq, imm16, j_address, rs_data, im_rdata,
    output im_addr, pc_F, instr_D, pc_D, valid_D, pc_err
  );
  modport slave (
    output stall, next_pc_op, cmp_eq, imm16, j_address, rs_data, im_rdata,
    input  im_addr, pc_F, instr_D, pc_D, valid_D, pc_err
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS program counter and IF/ID register; one delay slot, so nothing is ever squashed
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_3000,
  parameter int          IM_WORDS = 4096
) (
  input logic           clk,
  input logic           reset,
  fetch_stage_if.master f
);
  localparam logic [31:0] PC_END = PC_RESET + 32'(4 * IM_WORDS);
  logic [31:0] pc, pc_d, instr_d, seq, br_tgt, npc;
  logic [2:0]  op;
  logic        valid_d, err;
  // decision inputs carry no meaning until D holds a fetched instruction
  assign op     = valid_d ? f.next_pc_op : 3'd0;
  assign seq    = pc + 32'd4;
  assign br_tgt = pc_d + 32'd4 + {{14{f.imm16[15]}}, f.imm16, 2'b00};
  assign npc    = op == 3'd1 ? (f.cmp_eq ? br_tgt : seq)
                : op == 3'd2 ? {pc_d[31:28], f.j_address, 2'b00}
                : op == 3'd3 ? f.rs_data
                : seq;
  assign err    = (pc[1:0] != 2'b00) | (pc < PC_RESET) | (pc >= PC_END);
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      pc      <= PC_RESET;
      pc_d    <= '0;
      instr_d <= '0;
      valid_d <= 1'b0;
    end else if (!f.stall) begin
      pc      <= npc;
      pc_d    <= pc;
      instr_d <= err ? 32'h0 : f.im_rdata;
      valid_d <= 1'b1;
    end
  assign f.im_addr = pc;
  assign f.pc_F    = pc;
  assign f.pc_D    = pc_d;
  assign f.instr_D = instr_d;
  assign f.valid_D = valid_d;
  assign f.pc_err  = err;
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed test-plan scenarios plus randomized traffic checked against a behavioural model
module tb_fetch_stage;
  localparam logic [31:0] PC_RESET = 32'h0000_3000;
  localparam logic [31:0] PC_END   = 32'h0000_7000;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int n_checks = 0;
  int n_fail = 0;
  fetch_stage_if f();
  fetch_stage #(.PC_RESET(PC_RESET), .IM_WORDS(4096)) dut (.clk(clk), .reset(reset), .f(f));
  always #5 clk = ~clk;
  function automatic logic [31:0] im_word(logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction
  assign f.im_rdata = im_word(f.im_addr);
  function automatic logic m_err(logic [31:0] p);
    return p[1:0] != 2'b00 || p < PC_RESET || p >= PC_END;
  endfunction
  logic [31:0] m_pc, m_pc_d, m_instr;
  logic        m_valid;
  function automatic logic [31:0] model_npc();
    logic [31:0] n;
    n = m_pc + 32'd4;
    if (m_valid && f.next_pc_op == 3'd1 && f.cmp_eq) n = m_pc_d + 32'd4 + 32'($signed(f.imm16)) * 32'd4;
    if (m_valid && f.next_pc_op == 3'd2) n = {m_pc_d[31:28], f.j_address, 2'b00};
    if (m_valid && f.next_pc_op == 3'd3) n = f.rs_data;
    return n;
  endfunction
  always @(posedge clk or posedge reset)
    if (reset) begin
      m_pc <= PC_RESET; m_pc_d <= '0; m_instr <= '0; m_valid <= 1'b0;
    end else if (!f.stall) begin
      m_pc    <= model_npc();
      m_pc_d  <= m_pc;
      m_instr <= m_err(m_pc) ? 32'h0 : im_word(m_pc);
      m_valid <= 1'b1;
    end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    chk("model_pc_F", f.pc_F, m_pc);
    chk("model_im_addr", f.im_addr, m_pc);
    chk("model_pc_D", f.pc_D, m_pc_d);
    chk("model_instr_D", f.instr_D, m_instr);
    chk("model_valid_D", 32'(f.valid_D), 32'(m_valid));
    chk("model_pc_err", 32'(f.pc_err), 32'(m_err(m_pc)));
  end
  task automatic drive(logic [2:0] op, logic c, logic [15:0] imm, logic [25:0] ja, logic [31:0] rs, logic st);
    f.next_pc_op = op; f.cmp_eq = c; f.imm16 = imm; f.j_address = ja; f.rs_data = rs; f.stall = st;
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic seq_n(int n);
    drive(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    repeat (n) tick();
  endtask
  task automatic do_reset();
    drive(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
  endtask
  initial begin
    drive(3'd0, 1'b0, 16'h0, 26'h0, 32'h0, 1'b0);
    #2 reset = 1'b1;
    repeat (2) tick();
    chk("rst_pc_F", f.pc_F, 32'h3000);
    chk("rst_pc_D", f.pc_D, 32'h0);
    chk("rst_instr_D", f.instr_D, 32'h0);
    chk("rst_valid_D", 32'(f.valid_D), 32'h0);
    chk("rst_pc_err", 32'(f.pc_err), 32'h0);
    reset = 1'b0;
    tick();
    chk("seq1_pc_F", f.pc_F, 32'h3004);
    chk("seq1_instr_D", f.instr_D, im_word(32'h3000));
    chk("seq1_valid_D", 32'(f.valid_D), 32'h1);
    tick();
    chk("seq2_pc_F", f.pc_F, 32'h3008);
    chk("seq2_instr_D", f.instr_D, im_word(32'h3004));
    do_reset(); seq_n(4);
    chk("nt_pre_pc_D", f.pc_D, 32'h300C);
    drive(3'd1, 1'b0, 16'hFFFD, 26'h0, 32'h0, 1'b0); tick();
    chk("beq_nt_pc_F", f.pc_F, 32'h3014);
    do_reset(); seq_n(4);
    drive(3'd1, 1'b1, 16'hFFFD, 26'h0, 32'h0, 1'b0); tick();
    chk("beq_t_pc_F", f.pc_F, 32'h3004);
    chk("beq_slot_pc_D", f.pc_D, 32'h3010);
    chk("beq_slot_instr", f.instr_D, im_word(32'h3010));
    do_reset(); seq_n(9);
    chk("jal_pre_pc_D", f.pc_D, 32'h3020);
    drive(3'd2, 1'b0, 16'h0, 26'h0000C10, 32'h0, 1'b0); tick();
    chk("jal_pc_F", f.pc_F, 32'h3040);
    chk("jal_slot_pc_D", f.pc_D, 32'h3024);
    drive(3'd3, 1'b0, 16'h0, 26'h0, 32'h3024, 1'b0); tick();
    chk("jr_pc_F", f.pc_F, 32'h3024);
    chk("jr_slot_pc_D", f.pc_D, 32'h3040);
    do_reset(); seq_n(4);
    drive(3'd1, 1'b1, 16'hFFFD, 26'h0, 32'h0, 1'b1);
    repeat (3) begin
      tick();
      chk("stall_pc_F", f.pc_F, 32'h3010);
      chk("stall_pc_D", f.pc_D, 32'h300C);
      chk("stall_instr_D", f.instr_D, im_word(32'h300C));
    end
    drive(3'd1, 1'b1, 16'hFFFD, 26'h0, 32'h0, 1'b0); tick();
    chk("unstall_pc_F", f.pc_F, 32'h3004);
    do_reset(); seq_n(2);
    drive(3'd3, 1'b0, 16'h0, 26'h0, 32'h3002, 1'b0); tick();
    chk("misal_pc_err", 32'(f.pc_err), 32'h1);
    seq_n(1);
    chk("misal_nop", f.instr_D, 32'h0);
    chk("misal_seq_pc_F", f.pc_F, 32'h3006);
    chk("misal_err_held", 32'(f.pc_err), 32'h1);
    drive(3'd3, 1'b0, 16'h0, 26'h0, 32'h0000_2FFC, 1'b0); tick();
    chk("low_pc_err", 32'(f.pc_err), 32'h1);
    drive(3'd3, 1'b0, 16'h0, 26'h0, 32'hFFFF_FFFC, 1'b0); tick();
    seq_n(1);
    chk("wrap_pc_F", f.pc_F, 32'h0);
    chk("wrap_pc_err", 32'(f.pc_err), 32'h1);
    chk("wrap_nop", f.instr_D, 32'h0);
    do_reset(); seq_n(3);
    drive(3'd2, 1'b0, 16'h0, 26'h0001000, 32'h0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("async_pc_F", f.pc_F, 32'h3000);
    chk("async_pc_D", f.pc_D, 32'h0);
    chk("async_instr_D", f.instr_D, 32'h0);
    chk("async_valid_D", 32'(f.valid_D), 32'h0);
    tick();
    reset = 1'b0;
    tick();
    chk("async_nojump_pc_F", f.pc_F, 32'h3004);
    chk("async_nojump_pc_D", f.pc_D, 32'h3000);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] rs;
      logic [25:0] ja;
      logic [15:0] imm;
      rs  = ($urandom_range(0, 7) == 0) ? $urandom : PC_RESET + 32'(4 * $urandom_range(0, 40));
      ja  = ($urandom_range(0, 7) == 0) ? 26'($urandom) : 26'h0000C00 + 26'($urandom_range(0, 255));
      imm = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'(int'($urandom_range(0, 16)) - 8);
      drive(3'($urandom_range(0, 7)), 1'($urandom), imm, ja, rs, $urandom_range(0, 4) == 0);
      reset = $urandom_range(0, 99) == 0;
      tick();
    end
    reset = 1'b0;
    tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
